pc_sequencer: RTL and testbench

//   Instruction-cycle controller for the RV32I program counter. Sequences fetch -> execute -> PC update
//   and drives the PC's inc/load/Disable/ALU_out controls. Sits between the PC, the instruction-memory

---
 rtl/pc_ctrl_pkg.sv | 15 +
 rtl/pc_fetch_watchdog.sv | 34 +++
 rtl/pc_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and default constants for the RV32I PC instruction-cycle sequencer.
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    UPDATE,
    HALTED
  } state_t;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/pc_fetch_watchdog.sv
// Fetch watchdog: counts cycles spent waiting for an instruction-memory ack.
// Only present when PC_FETCH_TIMEOUT_EN is defined.
`ifdef PC_FETCH_TIMEOUT_EN
module pc_fetch_watchdog
  import pc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] count;

  // expire marks the TIMEOUT-th consecutive cycle of waiting
  assign expire = enable && (count == W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + W'(1);
    end
  end

endmodule
`endif

// File: rtl/pc_sequencer.sv
// Instruction-cycle controller driving the PC inc/load/ALU_out/Disable controls.
// Optional fetch watchdog enabled by defining PC_FETCH_TIMEOUT_EN.
module pc_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
`ifdef PC_FETCH_TIMEOUT_EN
  , parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             exec_done,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             halt_req,
  output logic             imem_req,
  output logic [31:0]      instr,
  output logic             exec_start,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             pc_alu_sel,
  output logic             pc_disable,
  output logic             halted,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retired
);

  state_t state;

`ifdef PC_FETCH_TIMEOUT_EN
  logic wd_expire;

  pc_fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .clr    (clr),
    .load   (state != FETCH),
    .enable (state == FETCH),
    .expire (wd_expire)
  );
`else
  assign fetch_err = 1'b0;
`endif

  // All outputs are registered alongside the state so they change on the state edge
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      instr      <= '0;
      retired    <= '0;
      imem_req   <= 1'b0;
      exec_start <= 1'b0;
      pc_inc     <= 1'b0;
      pc_load    <= 1'b0;
      pc_alu_sel <= 1'b0;
      pc_disable <= 1'b1;
      halted     <= 1'b0;
`ifdef PC_FETCH_TIMEOUT_EN
      fetch_err  <= 1'b0;
`endif
    end else begin
      exec_start <= 1'b0;
      pc_inc     <= 1'b0;
      pc_load    <= 1'b0;
      pc_alu_sel <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            instr      <= imem_rdata;
            exec_start <= 1'b1;
            imem_req   <= 1'b0;
            state      <= EXEC;
          end
`ifdef PC_FETCH_TIMEOUT_EN
          else if (wd_expire) begin
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            halted    <= 1'b1;
            state     <= HALTED;
          end
`endif
        end
        EXEC: begin
          // The redirect decision is captured straight into the UPDATE-cycle controls
          if (exec_done) begin
            if (halt_req) begin
              halted  <= 1'b1;
              retired <= retired + CNT_W'(1);
              state   <= HALTED;
            end else begin
              pc_disable <= 1'b0;
              if (jump || branch_taken) begin
                pc_load    <= 1'b1;
                pc_alu_sel <= jump;
              end else begin
                pc_inc <= 1'b1;
              end
              state <= UPDATE;
            end
          end
        end
        UPDATE: begin
          pc_disable <= 1'b1;
          retired    <= retired + CNT_W'(1);
          if (run) begin
            imem_req <= 1'b1;
            state    <= FETCH;
          end else begin
            state <= IDLE;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer with an attached PC register and memory/execute responders.
// Covers the PC_FETCH_TIMEOUT_EN watchdog when that macro is defined.
module tb_pc_sequencer;

  localparam logic [31:0] ALU_T = 32'h0000_0200;
  localparam logic [31:0] IMM   = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        clr;
  logic        run;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        exec_done;
  logic        branch_taken;
  logic        jump;
  logic        halt_req;
  logic        imem_req;
  logic [31:0] instr;
  logic        exec_start;
  logic        pc_inc;
  logic        pc_load;
  logic        pc_alu_sel;
  logic        pc_disable;
  logic        halted;
  logic        fetch_err;
  logic [31:0] retired;

  logic [31:0] pc;
  logic [31:0] exp_pc;
  logic [31:0] exp_retired;
  int          checks = 0;
  int          passes = 0;

  pc_sequencer #(
    .CNT_W   (32)
`ifdef PC_FETCH_TIMEOUT_EN
    , .TIMEOUT (8)
`endif
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .run          (run),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .exec_done    (exec_done),
    .branch_taken (branch_taken),
    .jump         (jump),
    .halt_req     (halt_req),
    .imem_req     (imem_req),
    .instr        (instr),
    .exec_start   (exec_start),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .pc_alu_sel   (pc_alu_sel),
    .pc_disable   (pc_disable),
    .halted       (halted),
    .fetch_err    (fetch_err),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  // Program counter driven by the sequencer controls
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc <= '0;
    end else if (!pc_disable) begin
      if (pc_load) pc <= pc_alu_sel ? ALU_T : pc + IMM;
      else if (pc_inc) pc <= pc + 32'd4;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One full instruction: wait for the request, answer after ack_dly cycles,
  // finish execution after exec_dly cycles and check the resulting PC update.
  task automatic apply_stimulus(input int ack_dly, input int exec_dly, input logic br,
                                input logic jp, input logic hl, input logic [31:0] word);
    int          waited;
    int          req_cycles;
    logic        frozen;
    logic [31:0] pc0;
    waited = 0;
    while (!imem_req && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check_output("req_seen", 32'(imem_req), 32'd1);
    pc0 = pc;
    frozen = 1'b1;
    req_cycles = 0;
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack  = 1'b0;
      exec_done = 1'($urandom_range(0, 1));
      halt_req  = 1'($urandom_range(0, 1));
      if (imem_req) req_cycles++;
      if (!pc_disable || pc !== pc0) frozen = 1'b0;
      @(negedge clk);
    end
    if (imem_req) req_cycles++;
    imem_ack   = 1'b1;
    imem_rdata = word;
    exec_done  = 1'b0;
    halt_req   = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    check_output("req_len", 32'(req_cycles), 32'(ack_dly + 1));
    check_output("pc_frozen", 32'(frozen), 32'd1);
    check_output("exec_start", 32'(exec_start), 32'd1);
    check_output("instr", instr, word);
    check_output("req_drop", 32'(imem_req), 32'd0);
    for (int j = 0; j < exec_dly; j++) begin
      imem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    imem_ack     = 1'b0;
    exec_done    = 1'b1;
    branch_taken = br;
    jump         = jp;
    halt_req     = hl;
    @(negedge clk);
    exec_done    = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    halt_req     = 1'b0;
    if (hl) begin
      exp_retired = exp_retired + 32'd1;
      check_output("halted", 32'(halted), 32'd1);
      check_output("halt_retired", retired, exp_retired);
      repeat (10) @(negedge clk);
      check_output("halt_pc", pc, exp_pc);
      check_output("halt_still", 32'(halted), 32'd1);
      check_output("halt_retired_hold", retired, exp_retired);
      check_output("halt_no_req", 32'(imem_req), 32'd0);
    end else begin
      check_output("upd_disable", 32'(pc_disable), 32'd0);
      check_output("upd_inc", 32'(pc_inc), 32'(!(br || jp)));
      check_output("upd_load", 32'(pc_load), 32'(br || jp));
      check_output("upd_sel", 32'(pc_alu_sel), 32'(jp));
      if (jp) exp_pc = ALU_T;
      else if (br) exp_pc = exp_pc + IMM;
      else exp_pc = exp_pc + 32'd4;
      exp_retired = exp_retired + 32'd1;
      @(negedge clk);
      check_output("pc", pc, exp_pc);
      check_output("retired", retired, exp_retired);
    end
  endtask

  initial begin
    int   ad;
    int   ed;
    logic rb;
    logic rj;

    clr          = 1'b0;
    run          = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = '0;
    exec_done    = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    halt_req     = 1'b0;
    exp_pc       = '0;
    exp_retired  = '0;
    repeat (2) @(negedge clk);

    check_output("rst_instr", instr, 32'd0);
    check_output("rst_retired", retired, 32'd0);
    check_output("rst_req", 32'(imem_req), 32'd0);
    check_output("rst_start", 32'(exec_start), 32'd0);
    check_output("rst_inc", 32'(pc_inc), 32'd0);
    check_output("rst_load", 32'(pc_load), 32'd0);
    check_output("rst_sel", 32'(pc_alu_sel), 32'd0);
    check_output("rst_disable", 32'(pc_disable), 32'd1);
    check_output("rst_halted", 32'(halted), 32'd0);
    check_output("rst_fetch_err", 32'(fetch_err), 32'd0);

    clr = 1'b1;
    @(negedge clk);
    check_output("idle_no_req", 32'(imem_req), 32'd0);
    run = 1'b1;

    // Back-to-back sequential instructions at minimum latency
    for (int k = 0; k < 3; k++) apply_stimulus(0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0013 + 32'(k));
    check_output("three_pc", pc, 32'd12);
    check_output("three_retired", retired, 32'd3);

    apply_stimulus(4, 0, 1'b0, 1'b0, 1'b0, 32'h1111_1111);
    apply_stimulus(0, 2, 1'b1, 1'b1, 1'b0, 32'h2222_2222);
    apply_stimulus(1, 1, 1'b1, 1'b0, 1'b0, 32'h3333_3333);
    apply_stimulus(2, 0, 1'b0, 1'b1, 1'b0, 32'h4444_4444);

    for (int k = 0; k < 15; k++) begin
      ad = $urandom_range(0, 3);
      ed = $urandom_range(0, 3);
      rb = 1'($urandom_range(0, 1));
      rj = 1'($urandom_range(0, 1));
      apply_stimulus(ad, ed, rb, rj, 1'b0, $urandom);
    end

    // Dropping run while the instruction is in flight parks in IDLE afterwards
    run = 1'b0;
    apply_stimulus(1, 1, 1'b0, 1'b0, 1'b0, 32'h5555_5555);
    repeat (3) @(negedge clk);
    check_output("park_no_req", 32'(imem_req), 32'd0);
    check_output("park_pc", pc, exp_pc);
    check_output("park_disable", 32'(pc_disable), 32'd1);
    run = 1'b1;
    apply_stimulus(0, 0, 1'b0, 1'b0, 1'b0, 32'h6666_6666);

    // Asynchronous clear in the middle of execution
    while (!imem_req) @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'h7777_7777;
    @(negedge clk);
    imem_ack = 1'b0;
    #2 clr = 1'b0;
    #1;
    check_output("clr_instr", instr, 32'd0);
    check_output("clr_retired", retired, 32'd0);
    check_output("clr_req", 32'(imem_req), 32'd0);
    check_output("clr_disable", 32'(pc_disable), 32'd1);
    check_output("clr_pc", pc, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    exp_pc = '0;
    exp_retired = '0;
    apply_stimulus(0, 0, 1'b0, 1'b0, 1'b0, 32'h8888_8888);
    apply_stimulus(0, 0, 1'b1, 1'b0, 1'b0, 32'h9999_9999);

`ifndef PC_FETCH_TIMEOUT_EN
    apply_stimulus(20, 0, 1'b0, 1'b0, 1'b0, 32'hAAAA_AAAA);
    check_output("no_fetch_err", 32'(fetch_err), 32'd0);
`endif

    apply_stimulus(1, 1, 1'b0, 1'b0, 1'b1, 32'h0000_0073);

`ifdef PC_FETCH_TIMEOUT_EN
    begin
      int req_cnt;
      clr = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      req_cnt = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (imem_req) req_cnt++;
      end
      check_output("wd_req_cycles", 32'(req_cnt), 32'd8);
      check_output("wd_fetch_err", 32'(fetch_err), 32'd1);
      check_output("wd_halted", 32'(halted), 32'd1);
      check_output("wd_req_low", 32'(imem_req), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
